uart_rx_os: RTL

- UART receiver with 16x oversampling.
- Sits downstream of the team's baud tick generator and consumes its one-clock `s_tick` pulse; the divisor is set so that ticks occur at 16x the baud rate.
- Detects the start bit, samples each bit at mid-period, and optionally checks parity.
- Presents each received byte with a one-clock done strobe plus parity and framing status, for a FIFO or bus interface downstream.

---
 rtl/uart_rx_os.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// UART receiver that uses 16x oversampling of the serial line.
// It finds the start bit, samples each bit at mid-period and flags parity and framing errors.
module uart_rx_os #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic PEN = (PARITY_EN != 0);
    localparam logic POD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [4:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            p;

    // Frame FSM: counts oversample ticks and bits, and registers the results when the stop bit ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            p            <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == 5'd7) begin
                            if (!rx) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == 5'd15) begin
                            s <= '0;
                            b <= {rx, b[DBIT-1:1]};
                            if (n == N_LAST) begin
                                state <= PEN ? PARITY : STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s == 5'd15) begin
                            p     <= rx;
                            s     <= '0;
                            state <= STOP;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            state        <= IDLE;
                            rx_done_tick <= 1'b1;
                            dout         <= b;
                            frame_err    <= ~rx;
                            parity_err   <= PEN & (^b ^ p ^ POD);
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
